// File: rtl/wb_regfile.sv
// Write-back stage and 8x16 register file with a per-register in-flight scoreboard for RAW stalls.
// Optional write-through forwarding is enabled by defining WB_BYPASS_EN.
module wb_regfile (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic [15:0] WB_DATA,
    input  logic [1:0]  WB_OP,
    input  logic [2:0]  WB_DEST,
    input  logic        ISSUE_VALID,
    input  logic        ISSUE_WRITES,
    input  logic [2:0]  ISSUE_DEST,
    input  logic [2:0]  RS_ADDR,
    input  logic [2:0]  RT_ADDR,
    input  logic        RS_USE,
    input  logic        RT_USE,
    output logic [15:0] RS_DATA,
    output logic [15:0] RT_DATA,
    output logic        STALL,
    output logic [15:0] RETIRE_COUNT,
    output logic        SB_ERR
);

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_ALU  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;

    logic [15:0] regs [8];
    logic [1:0]  pend [8];
    logic [7:0]  busy;
    logic        wb_write;
    logic        issue_ev;

    // A write-back to R0 is neither a register write nor a scoreboard retire.
    assign wb_write = ((WB_OP == OP_ALU) || (WB_OP == OP_LOAD)) && (WB_DEST != 3'd0);
    assign issue_ev = ISSUE_VALID && ISSUE_WRITES && !STALL && (ISSUE_DEST != 3'd0);

    always_comb begin
        busy = '0;
        for (int i = 1; i < 8; i++) begin
`ifdef WB_BYPASS_EN
            busy[i] = (pend[i] != 2'd0) &&
                      !((pend[i] == 2'd1) && wb_write && (WB_DEST == 3'(i)));
`else
            busy[i] = (pend[i] != 2'd0);
`endif
        end
    end

    assign STALL = (RS_USE && busy[RS_ADDR]) || (RT_USE && busy[RT_ADDR]);

    always_comb begin
        RS_DATA = regs[RS_ADDR];
        RT_DATA = regs[RT_ADDR];
`ifdef WB_BYPASS_EN
        // Forwarding is masked during reset so the read ports show the cleared file.
        if (wb_write && !RESET && (RS_ADDR == WB_DEST)) RS_DATA = WB_DATA;
        if (wb_write && !RESET && (RT_ADDR == WB_DEST)) RT_DATA = WB_DATA;
`endif
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= 16'h0000;
                pend[i] <= 2'd0;
            end
            RETIRE_COUNT <= 16'h0000;
            SB_ERR       <= 1'b0;
        end else begin
            if (wb_write) regs[WB_DEST] <= WB_DATA;
            if (WB_OP != OP_NOP) RETIRE_COUNT <= RETIRE_COUNT + 16'd1;
            for (int i = 1; i < 8; i++) begin
                // Simultaneous issue and retire on one register cancel out.
                if (issue_ev && (ISSUE_DEST == 3'(i)) && !(wb_write && (WB_DEST == 3'(i)))) begin
                    if (pend[i] == 2'd3) SB_ERR <= 1'b1;
                    else                 pend[i] <= pend[i] + 2'd1;
                end else if (wb_write && (WB_DEST == 3'(i)) && !(issue_ev && (ISSUE_DEST == 3'(i)))) begin
                    if (pend[i] == 2'd0) SB_ERR <= 1'b1;
                    else                 pend[i] <= pend[i] - 2'd1;
                end
            end
        end
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file for the 5-stage 16-bit pipeline. It consumes the MEM-stage output latch (result data, 2-bit op, 3-bit destination) and commits ALU and load results to eight 16-bit registers. It provides two read ports to decode. A per-register in-flight scoreboard drives a decode stall for read-after-write hazards.

## Interface
Parameters:
- none; widths fixed: 16-bit data, 8 registers (3-bit index), 2-bit op.

Ports:
- CLOCK_50  in  1  system clock; all state updates on rising edge
- RESET  in  1  asynchronous, active-high
- WB_DATA  in  16  result from MEM latch (ALU result or load data)
- WB_OP  in  2  op from MEM latch: 00 nop, 01 ALU, 10 load, 11 store
- WB_DEST  in  3  destination register from MEM latch
- ISSUE_VALID  in  1  decode issues an instruction this cycle
- ISSUE_WRITES  in  1  issued instruction writes a register (op 01/10)
- ISSUE_DEST  in  3  destination of issued instruction
- RS_ADDR, RT_ADDR  in  3 each  decode read-port addresses
- RS_USE, RT_USE  in  1 each  decode actually needs the operand
- RS_DATA, RT_DATA  out  16 each  read-port data, combinational
- STALL  out  1  combinational RAW hazard; decode must hold
- RETIRE_COUNT  out  16  retired non-nop instructions, wraps
- SB_ERR  out  1  sticky scoreboard over/underflow flag

## Operation
- Write-back: the block writes WB_DATA to R[WB_DEST] when WB_OP is 01 or 10 and WB_DEST != 0. R0 is hardwired to 0; writes to R0 are dropped. Ops 00 and 11 never write.
- Retire: RETIRE_COUNT increments by 1 when WB_OP != 00. Wraps from 0xFFFF to 0x0000.
- Scoreboard: each register has a 2-bit pending counter, PEND[r].
  - Issue event: ISSUE_VALID && ISSUE_WRITES && !STALL && ISSUE_DEST != 0.
  - Retire event: WB_OP in {01,10} && WB_DEST != 0.
  - Issue only on r: PEND[r] += 1. Retire only on r: PEND[r] -= 1. Both on the same r: PEND[r] unchanged.
  - Issue with PEND[r]==3: PEND[r] stays 3 and SB_ERR is set.
  - Retire with PEND[r]==0: PEND[r] stays 0 and SB_ERR is set.
  - ISSUE_VALID while STALL=1 is ignored entirely.
- busy(r): PEND[r] != 0, modified by the bypass option (see Configuration). R0 is never busy.
- STALL = (RS_USE && busy(RS_ADDR)) || (RT_USE && busy(RT_ADDR)).
- Read ports: RS_DATA = R[RS_ADDR] and RT_DATA = R[RT_ADDR], subject to bypass (see Configuration).

## Timing
- Write-back latency: a write is visible in R[] from the edge following WB_OP/WB_DEST presentation.
- Reset (async): all R[] = 0, PEND[] = 0, RETIRE_COUNT = 0, SB_ERR = 0. Output values during reset:
  - STALL = 0 when RS_USE = RT_USE = 0.
  - RS_DATA and RT_DATA = 0.
- Reset mid-operation: all pending state is discarded. No write occurs on the edge coinciding with RESET high.
- SB_ERR is cleared only by RESET.
- Back-to-back writes to the same register: the last write wins, one per cycle.

## Configuration
- WB_BYPASS_EN defined: internal write-through.
  - A read port whose address equals WB_DEST during a write-back cycle returns WB_DATA.
  - busy(r) excludes a register with PEND[r]==1 that is retiring this cycle.
  - Dependent instruction can read in the same cycle as the producer's write-back.
- WB_BYPASS_EN undefined:
  - Reads return stored R[] only.
  - busy(r) = PEND[r] != 0.
  - Dependent instruction stalls through the write-back cycle; this costs one extra stall cycle per RAW hazard.

## Test plan
- Reset, then WB_OP=01, WB_DEST=3, WB_DATA=0xBEEF -> R3 reads 0xBEEF next cycle; RETIRE_COUNT=1.
- WB_OP=10, WB_DEST=0, WB_DATA=0x1234 -> R0 still reads 0x0000. WB_OP=11 on R5 -> R5 unchanged; RETIRE_COUNT increments.
- Issue writer to R2, then RS_ADDR=2, RS_USE=1 -> STALL=1 until retire.
  - With WB_BYPASS_EN: STALL drops in the retire cycle and RS_DATA = WB_DATA.
  - Without it: STALL drops one cycle later.
- Issue and retire R4 in the same cycle with PEND[4]=1 -> PEND[4] stays 1 and STALL remains for R4 readers.
- Four issues to R6 without retire -> fourth sets SB_ERR=1 and PEND[6]=3. Retire to R1 with PEND[1]=0 -> SB_ERR stays 1.
- RETIRE_COUNT preloaded to 0xFFFF via 65535 retires, one more retire -> 0x0000. Assert RESET mid-stream -> all outputs return to reset values asynchronously.
